riscv_dbus_uart_tx: RTL and testbench
=====================================

// Module: riscv_dbus_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter that responds on the riscv_core data bus, in parallel with riscv_memory.
//  The core writes bytes into a TX FIFO. An 8N1 serialiser drains the FIFO to txd_o at a programmable baud rate.
//  Status, divisor and control registers can be read back over the same bus. Gives firmware a console/debug output.
// PARAMETERS
//  BASE_ADDR      32'h8000_0000  register window base; decode on daddr_i[31:4]==BASE_ADDR[31:4]
//  DIV_RESET      16'd868        reset value of DIVISOR (clk cycles per bit)
//  FIFO_DEPTH     8              TX FIFO entries; power of 2, 2..16
// PORTS
//  clk_i      in   1   clock, all logic on rising edge
//  reset_i    in   1   synchronous reset, active-high
//  daddr_i    in   32  data bus byte address
//  dwdata_i   in   32  write data, LSB-justified per dsize_i
//  drdata_o   out  32  read data, registered
//  dsize_i    in   2   0=byte 1=half 2=word; 3 treated as word
//  drd_i      in   1   read strobe, one cycle per access
//  dwr_i      in   1   write strobe, one cycle per access
//  txd_o      out  1   serial output, idle high
//  irq_o      out  1   TX-empty interrupt, level
// BEHAVIOUR
//  Reset values:
//   drdata_o=0, txd_o=1, irq_o=0, FIFO empty, DIVISOR=DIV_RESET, CTRL=0, OVF=0, FSM=IDLE.
//  Access rules:
//   - An access hits only if the window matches and daddr_i[1:0]==0. Misaligned or unmapped accesses: writes ignored, reads return 0.
//   - dsize_i masks write data: byte=[7:0], half=[15:0], word=[31:0]. Unwritten register bits are left unchanged.
//  Register map (offset):
//   0x0 TXDATA  W: push dwdata_i[7:0]; R: 0
//   0x4 STATUS  R: [0]busy [1]full [2]empty [3]OVF [8:4]count; W: writing 1 to bit3 clears OVF
//   0x8 DIVISOR RW [15:0]; value 0 behaves as 1
//   0xC CTRL    RW [0]tx_en [1]irq_en
//  Read timing:
//   - drd_i in cycle N -> drdata_o valid in cycle N+1. drdata_o holds its value until the next read.
//   - drd_i and dwr_i in the same cycle: the write wins, and the read returns 0.
//  FIFO:
//   - A push when full is dropped and sets OVF (sticky).
//   - A push and a pop in the same cycle: fullness is judged on the pre-pop count, so a push when full is still dropped.
//  Serialiser FSM:
//   - IDLE: txd=1. If tx_en & !empty: pop a byte into the shift register, load the baud counter, go to START.
//   - START: txd=0 for DIVISOR cycles, then go to DATA with bit index 0.
//   - DATA: txd=shift[0] (LSB first) for DIVISOR cycles per bit. After bit 7, go to STOP.
//   - STOP: txd=1 for DIVISOR cycles. Then go to START if tx_en & !empty (back-to-back frames, pop on that edge); otherwise go to IDLE.
//   - DIVISOR is sampled at each bit start. A write mid-bit takes effect on the next bit.
//   - Clearing tx_en mid-frame completes the current frame, then the FSM stays in IDLE.
//  Flags and interrupt:
//   - busy=1 whenever FSM!=IDLE.
//   - irq_o = irq_en & empty & !busy, registered (1 cycle after the condition holds).
//  Reset mid-frame: txd_o returns to 1 next cycle and the FIFO contents are discarded.
// TESTING
//  T1 Reset:
//     reset_i=1 for 2 cycles -> txd_o=1, irq_o=0; read 0x8 -> 868; read 0x4 -> 0x004 (empty).
//  T2 Single frame:
//     Write DIVISOR=4, CTRL=1, TXDATA=0x A5 -> txd_o shows 0, then 1,0,1,0,0,1,0,1, then 1.
//     Each bit lasts 4 cycles; total frame is 40 cycles; busy is 0 afterwards.
//  T3 Overflow:
//     CTRL=0, push 9 bytes with DEPTH=8 -> STATUS reads full=1, OVF=1, count=8.
//     Write 0x8 to STATUS -> OVF=0.
//  T4 Back-to-back:
//     DIVISOR=2, push 0x01 and 0x80, then set CTRL=1 -> 40 cycles contiguous, no idle gap between frames.
//  T5 Interrupt:
//     CTRL=3, push 1 byte -> irq_o=0 during the frame, irq_o=1 one cycle after the FSM returns to IDLE.
//  T6 Bus edge cases:
//     Read 0x8000_0006 -> 0. Byte write 0x1234 to DIVISOR -> DIVISOR=0x??34 (upper byte unchanged).
//     Reset asserted mid-DATA -> txd_o=1 next cycle.

Source files
------------

// File: rtl/riscv_dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the riscv_core data bus.
// TX FIFO fed by bus writes, drained by a programmable-baud serialiser.
module riscv_dbus_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter logic [15:0] DIV_RESET  = 16'd868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] daddr_i,
    input  logic [31:0] dwdata_i,
    output logic [31:0] drdata_o,
    input  logic [1:0]  dsize_i,
    input  logic        drd_i,
    input  logic        dwr_i,
    output logic        txd_o,
    output logic        irq_o
);

    localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   div_q, div_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   drdata_q, drdata_d;
    logic          txd_q, txd_d;
    logic          irq_q, irq_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [4:0]    count_q, count_d;

    logic          hit;
    logic [15:0]   wmask;
    logic [15:0]   wdata_m;
    logic          wr_txdata, wr_status, wr_div, wr_ctrl;
    logic          full, empty, busy;
    logic          push_ok, push_drop, pop;
    logic [15:0]   div_eff;
    logic          bit_end;
    logic [31:0]   rdata_sel;
    logic          unused_wdata;

    assign unused_wdata = ^dwdata_i[31:16];

    // Only aligned accesses inside the 16-byte window are decoded.
    assign hit       = (daddr_i[31:4] == BASE_ADDR[31:4]) && (daddr_i[1:0] == 2'b00);
    assign wmask     = (dsize_i == 2'd0) ? 16'h00FF : 16'hFFFF;
    assign wdata_m   = dwdata_i[15:0] & wmask;

    assign wr_txdata = dwr_i && hit && (daddr_i[3:2] == 2'd0);
    assign wr_status = dwr_i && hit && (daddr_i[3:2] == 2'd1);
    assign wr_div    = dwr_i && hit && (daddr_i[3:2] == 2'd2);
    assign wr_ctrl   = dwr_i && hit && (daddr_i[3:2] == 2'd3);

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == 5'd0);
    assign busy      = (state_q != S_IDLE);

    // Fullness is judged before any same-cycle pop.
    assign push_ok   = wr_txdata && !full;
    assign push_drop = wr_txdata && full;

    assign div_eff   = (div_q == 16'd0) ? 16'd1 : div_q;
    assign bit_end   = (baud_q == 16'd0);

    always_comb begin
        div_d  = div_q;
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        if (wr_div) begin
            div_d = (div_q & ~wmask) | wdata_m;
        end
        if (wr_ctrl) begin
            ctrl_d = (ctrl_q & ~wmask[1:0]) | wdata_m[1:0];
        end
        if (wr_status && wdata_m[3]) begin
            ovf_d = 1'b0;
        end
        if (push_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        count_d = count_q + {4'b0, push_ok} - {4'b0, pop};
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0] && !empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    baud_d  = div_eff - 16'd1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    baud_d  = div_eff - 16'd1;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = div_eff - 16'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d  = baud_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (ctrl_q[0] && !empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        baud_d  = div_eff - 16'd1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d  = baud_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Line level is registered from the next state so it changes with the state.
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        case (daddr_i[3:2])
            2'd1:    rdata_sel = {23'b0, count_q, ovf_q, empty, full, busy};
            2'd2:    rdata_sel = {16'b0, div_q};
            2'd3:    rdata_sel = {30'b0, ctrl_q};
            default: rdata_sel = '0;
        endcase
        drdata_d = drdata_q;
        if (drd_i) begin
            drdata_d = (hit && !dwr_i) ? rdata_sel : '0;
        end
        irq_d = ctrl_q[1] && empty && !busy;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= dwdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            div_q    <= DIV_RESET;
            ctrl_q   <= '0;
            ovf_q    <= 1'b0;
            drdata_q <= '0;
            txd_q    <= 1'b1;
            irq_q    <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            drdata_q <= drdata_d;
            txd_q    <= txd_d;
            irq_q    <= irq_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
        end
    end

    assign drdata_o = drdata_q;
    assign txd_o    = txd_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_riscv_dbus_uart_tx.sv
// Directed and randomized bench for riscv_dbus_uart_tx; expected line levels
// come from an arithmetic 8N1 frame model and a byte queue.
module tb_riscv_dbus_uart_tx;

    localparam logic [31:0] A_TX   = 32'h8000_0000;
    localparam logic [31:0] A_STAT = 32'h8000_0004;
    localparam logic [31:0] A_DIV  = 32'h8000_0008;
    localparam logic [31:0] A_CTRL = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] daddr = '0;
    logic [31:0] dwdata = '0;
    logic [31:0] drdata;
    logic [1:0]  dsize = 2'd2;
    logic        drd = 1'b0;
    logic        dwr = 1'b0;
    logic        txd;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_dbus_uart_tx #(
        .BASE_ADDR (32'h8000_0000),
        .DIV_RESET (16'd868),
        .FIFO_DEPTH(8)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .daddr_i (daddr),
        .dwdata_i(dwdata),
        .drdata_o(drdata),
        .dsize_i (dsize),
        .drd_i   (drd),
        .dwr_i   (dwr),
        .txd_o   (txd),
        .irq_o   (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        daddr = a; dwdata = d; dsize = sz; dwr = 1'b1;
        @(negedge clk);
        dwr = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        daddr = a; dsize = 2'd2; drd = 1'b1;
        @(negedge clk);
        drd = 1'b0;
        chk(tag, drdata, exp);
    endtask

    // Expected level of sample s in a frame: start, 8 data bits LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int unsigned s, input int unsigned de);
        int unsigned pos;
        pos = s / de;
        if (pos == 0) return 1'b0;
        if (pos >= 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic frame_chk(input string tag, input logic [7:0] b, input int unsigned d,
                             input bit contig, input bit irq0);
        int unsigned de;
        logic found;
        de = (d == 0) ? 1 : d;
        if (!contig) begin
            found = 1'b0;
            for (int i = 0; i < 300 && !found; i++) begin
                @(negedge clk);
                if (txd === 1'b0) found = 1'b1;
            end
            chk({tag, "_start"}, {31'b0, found}, 32'd1);
            if (!found) return;
        end
        for (int unsigned s = 0; s < 10 * de; s++) begin
            if (s > 0 || contig) @(negedge clk);
            chk(tag, {31'b0, txd}, {31'b0, frame_bit(b, s, de)});
            if (irq0) chk("irq_in_frame", {31'b0, irq}, 32'd0);
        end
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [7:0]  b;
        int unsigned d;

        // T1 reset
        repeat (2) @(negedge clk);
        chk("rst_txd", {31'b0, txd}, 32'd1);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_drdata", drdata, 32'd0);
        reset = 1'b0;
        read_chk("rst_div", A_DIV, 32'd868);
        read_chk("rst_status", A_STAT, 32'h004);
        read_chk("rst_ctrl", A_CTRL, 32'd0);

        // T2 single frame, then randomized frames with assorted divisors
        bus_write(A_DIV, 32'd4, 2'd2);
        bus_write(A_CTRL, 32'd1, 2'd2);
        bus_write(A_TX, 32'h0000_00A5, 2'd0);
        frame_chk("frame_a5", 8'hA5, 4, 1'b0, 1'b0);
        @(negedge clk);
        chk("idle_txd", {31'b0, txd}, 32'd1);
        read_chk("idle_status", A_STAT, 32'h004);
        for (int k = 0; k < 6; k++) begin
            d = $urandom_range(0, 5);
            b = 8'($urandom);
            bus_write(A_DIV, d, 2'd2);
            bus_write(A_TX, {24'($urandom), b}, 2'd2);
            frame_chk("frame_rand", b, d, 1'b0, 1'b0);
        end
        @(negedge clk);

        // T3 overflow, then drain the FIFO back-to-back at divisor 1
        bus_write(A_CTRL, 32'd0, 2'd2);
        for (int k = 0; k < 9; k++) begin
            b = 8'($urandom);
            if (q.size() < 8) q.push_back(b);
            bus_write(A_TX, {24'd0, b}, 2'd0);
        end
        read_chk("ovf_status", A_STAT, 32'h08A);
        bus_write(A_STAT, 32'h8, 2'd2);
        read_chk("ovf_clear", A_STAT, 32'h082);
        bus_write(A_DIV, 32'd1, 2'd2);
        bus_write(A_CTRL, 32'd1, 2'd2);
        for (int k = 0; k < 8; k++) begin
            frame_chk("drain", q.pop_front(), 1, (k != 0), 1'b0);
        end
        @(negedge clk);
        chk("drain_idle", {31'b0, txd}, 32'd1);

        // T4 back-to-back frames with no gap
        bus_write(A_CTRL, 32'd0, 2'd2);
        bus_write(A_DIV, 32'd2, 2'd2);
        bus_write(A_TX, 32'h01, 2'd0);
        bus_write(A_TX, 32'h80, 2'd0);
        bus_write(A_CTRL, 32'd1, 2'd2);
        frame_chk("b2b_01", 8'h01, 2, 1'b0, 1'b0);
        frame_chk("b2b_80", 8'h80, 2, 1'b1, 1'b0);
        @(negedge clk);
        chk("b2b_idle", {31'b0, txd}, 32'd1);

        // T5 interrupt low during the frame, high one cycle after IDLE
        bus_write(A_CTRL, 32'd0, 2'd2);
        bus_write(A_DIV, 32'd3, 2'd2);
        b = 8'($urandom);
        bus_write(A_TX, {24'd0, b}, 2'd0);
        bus_write(A_CTRL, 32'd3, 2'd2);
        frame_chk("irq_frame", b, 3, 1'b0, 1'b1);
        @(negedge clk);
        chk("irq_at_idle", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_after_idle", {31'b0, irq}, 32'd1);
        bus_write(A_CTRL, 32'd1, 2'd2);
        chk("irq_hold", {31'b0, irq}, 32'd1);
        @(negedge clk);
        chk("irq_disabled", {31'b0, irq}, 32'd0);

        // T6 bus edge cases
        read_chk("misaligned_rd", 32'h8000_0006, 32'd0);
        read_chk("unmapped_rd", 32'h8000_0018, 32'd0);
        bus_write(A_DIV, 32'h0000_ABCD, 2'd2);
        bus_write(A_DIV, 32'h0000_1234, 2'd0);
        read_chk("div_byte_wr", A_DIV, 32'h0000_AB34);
        repeat (3) @(negedge clk);
        chk("drdata_hold", drdata, 32'h0000_AB34);
        bus_write(A_DIV, 32'h00FF_5678, 2'd1);
        read_chk("div_half_wr", A_DIV, 32'h0000_5678);
        bus_write(32'h8000_0009, 32'h0000_0007, 2'd2);
        read_chk("misaligned_wr", A_DIV, 32'h0000_5678);
        bus_write(A_CTRL, 32'hFFFF_FFFE, 2'd2);
        read_chk("ctrl_mask", A_CTRL, 32'd2);
        @(negedge clk);
        daddr = A_DIV; dwdata = 32'h42; dsize = 2'd2; dwr = 1'b1; drd = 1'b1;
        @(negedge clk);
        dwr = 1'b0; drd = 1'b0;
        chk("rd_wr_collide", drdata, 32'd0);
        read_chk("collide_wr_took", A_DIV, 32'h42);

        // Reset mid-DATA with more bytes queued
        bus_write(A_CTRL, 32'd0, 2'd2);
        bus_write(A_DIV, 32'd4, 2'd2);
        bus_write(A_TX, 32'h00, 2'd0);
        bus_write(A_TX, 32'h55, 2'd0);
        bus_write(A_TX, 32'h66, 2'd0);
        bus_write(A_CTRL, 32'd1, 2'd2);
        for (int i = 0; i < 50 && txd !== 1'b0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        chk("mid_data_txd", {31'b0, txd}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_txd", {31'b0, txd}, 32'd1);
        reset = 1'b0;
        read_chk("reset_fifo", A_STAT, 32'h004);
        read_chk("reset_div", A_DIV, 32'd868);
        repeat (5) @(negedge clk);
        chk("reset_quiet", {31'b0, txd}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
